ks_pipe_adder: RTL and testbench
================================

// Module: ks_pipe_adder
// PURPOSE
//  Parametrised, pipelined Kogge-Stone adder with valid/ready handshake on both sides.
//  Generalises the fixed 16-bit combinational KoggeStone adder: arbitrary WIDTH, selectable
//  pipeline depth (prefix levels per register stage) and downstream backpressure.
//  Sits in the datapath between an operand producer and a result consumer, one add per beat.
// PARAMETERS
//  WIDTH         16  operand/sum width in bits; legal range >= 2, any value (need not be 2^n)
//  STAGE_LEVELS  2   prefix levels evaluated between pipeline registers; legal range >= 1
//  (derived) LOG2W = $clog2(WIDTH); NSTG = ceil(LOG2W/STAGE_LEVELS); LAT = NSTG + 1
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand beat present
//  in_ready   out  1      block accepts operand beat this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry in
//  out_valid  out  1      result beat present
//  out_ready  in   1      consumer accepts result this cycle
//  out_sum    out  WIDTH  sum bits
//  out_cout   out  1      carry out; {out_cout,out_sum} == in_a + in_b + in_cin (WIDTH+1 bits)
// BEHAVIOUR
//  - One clock (clk); reset asynchronous, active-low (rst_n). On rst_n=0: every stage valid
//    bit, all pipeline data, out_valid, out_sum, out_cout cleared to 0, regardless of traffic.
//  - Stage 0 (registered on accept): p_i=a_i^b_i, g_i=a_i&b_i; cin folded into bit 0:
//    g_0 = a_0&b_0 | (a_0^b_0)&cin. Original p vector carried to the end for sum formation.
//  - Prefix: level k (k=0..LOG2W-1) combines span 2^k: G=Gh|Ph&Gl, P=Ph&Pl; bits i<2^k pass.
//    Register after every STAGE_LEVELS levels; the last group registers into the output stage.
//  - Output: sum_i = p_i ^ C_(i-1) with C_(-1)=cin; cout = group G over [WIDTH-1:0].
//  - Latency: accepted beat appears on out_valid exactly LAT cycles later absent stalls
//    (WIDTH=16, STAGE_LEVELS=2: LAT=3; STAGE_LEVELS>=LOG2W: LAT=2).
//  - Handshake: input transfer when in_valid&in_ready; output transfer when out_valid&out_ready.
//    stall = out_valid & ~out_ready. in_ready = ~stall (combinational). While stall, every
//    stage register holds (valid and data); no beat lost, duplicated or reordered.
//  - Bubbles: empty stages advance when not stalled; in_valid=0 injects valid=0 bubble.
//  - out_sum/out_cout stable while out_valid & ~out_ready; don't-care value when out_valid=0
//    but must be the last registered result (no X after reset).
//  - Throughput: 1 beat/cycle with out_ready held 1. in_ready depends on out_ready only.
//  - Wrap-around: all-ones + 1 -> out_sum=0, out_cout=1; no saturation.
//  - Reset mid-operation: in-flight beats discarded; first beat after release is first out.
// CONFIGURATION
//  KS_PIPE_SUB_EN defined: adds port in_sub (in, 1), captured with the operand beat;
//    in_sub=1 computes in_a + ~in_b + 1 (in_cin ignored), out_cout = NOT borrow
//    (1 when in_a >= in_b unsigned). in_sub=0 identical to the non-SUB build.
//  KS_PIPE_SUB_EN undefined: no in_sub port; always add with in_cin.
// TESTING
//  1 WIDTH=16: a=0x1234,b=0x4321,cin=0 -> LAT=3 cycles later sum=0x5555,cout=0.
//  2 WIDTH=16: a=0xFFFF,b=0x0000,cin=1 -> sum=0x0000,cout=1; a=0x8000,b=0x8000,cin=0 -> 0x0000,1.
//  3 Streaming 100x100 operand table, out_ready=1 -> 1 result/cycle, every {cout,sum} == a+b+cin.
//  4 Stream 8 beats, drop out_ready for 5 cycles at beat 3 -> in_ready=0 those cycles, out held,
//    all 8 results in order, none lost/duplicated.
//  5 Assert rst_n=0 with 3 beats in flight -> out_valid=0,out_sum=0,out_cout=0 immediately;
//    after release next beat emerges after LAT cycles.
//  6 WIDTH=13,STAGE_LEVELS=1 (LAT=5) random stress vs reference model; with KS_PIPE_SUB_EN,
//    a=0x0005,b=0x0007,in_sub=1 -> sum=0x1FFE,cout=0.

Source files
------------

// File: rtl/ks_pipe_if.sv
// Operand/result handshake bundle for ks_pipe_adder.
// The in_sub signal exists only when KS_PIPE_SUB_EN is defined.
`timescale 1ns/1ps
interface ks_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
`ifdef KS_PIPE_SUB_EN
  logic             in_sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

`ifdef KS_PIPE_SUB_EN
  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
`endif
endinterface

// File: rtl/ks_pipe_adder.sv
// Pipelined Kogge-Stone adder, STAGE_LEVELS prefix levels per register stage, valid/ready on both sides.
// Optional KS_PIPE_SUB_EN adds in_sub: computes in_a + ~in_b + 1, out_cout = NOT borrow.
`timescale 1ns/1ps
module ks_pipe_adder #(
  parameter int WIDTH        = 16,
  parameter int STAGE_LEVELS = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  ks_pipe_if.slave bus
);
  localparam int LOG2W = $clog2(WIDTH);
  localparam int NSTG  = (LOG2W + STAGE_LEVELS - 1) / STAGE_LEVELS;

  // One prefix level of span 'span': bits below span pass through unchanged.
  function automatic logic [2*WIDTH-1:0] ks_level(input logic [WIDTH-1:0] g,
                                                  input logic [WIDTH-1:0] p,
                                                  input int               span);
    logic [WIDTH-1:0] gn;
    logic [WIDTH-1:0] pn;
    gn = g | (p & (g << span));
    pn = p & ((p << span) | ~({WIDTH{1'b1}} << span));
    return {gn, pn};
  endfunction

  logic [NSTG-1:0]  vld_q;
  logic [WIDTH-1:0] g_q   [NSTG];
  logic [WIDTH-1:0] p_q   [NSTG];
  logic [WIDTH-1:0] po_q  [NSTG];
  logic [NSTG-1:0]  cin_q;
  logic [WIDTH-1:0] grp_g_d [NSTG];
  logic [WIDTH-1:0] grp_p_d [NSTG];

  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_cout_q;

  logic [WIDTH-1:0] b_eff_d;
  logic [WIDTH-1:0] g0_d;
  logic [WIDTH-1:0] p0_d;
  logic             cin0_d;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             stall_d;
  logic             unused_p_top;

  assign stall_d       = out_valid_q & ~bus.out_ready;
  assign bus.in_ready  = ~stall_d;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;
  assign unused_p_top  = ^grp_p_d[NSTG-1];

  // Stage-0 generate/propagate with the carry-in folded into bit 0.
  always_comb begin
    b_eff_d = bus.in_b;
    cin0_d  = bus.in_cin;
`ifdef KS_PIPE_SUB_EN
    if (bus.in_sub) begin
      b_eff_d = ~bus.in_b;
      cin0_d  = 1'b1;
    end else begin
      b_eff_d = bus.in_b;
      cin0_d  = bus.in_cin;
    end
`endif
    p0_d    = bus.in_a ^ b_eff_d;
    g0_d    = bus.in_a & b_eff_d;
    g0_d[0] = g0_d[0] | (p0_d[0] & cin0_d);
  end

  // Prefix levels evaluated between each pair of pipeline registers.
  always_comb begin
    logic [WIDTH-1:0] gw;
    logic [WIDTH-1:0] pw;
    for (int s = 0; s < NSTG; s++) begin
      gw = g_q[s];
      pw = p_q[s];
      for (int l = 0; (l < STAGE_LEVELS) && ((s * STAGE_LEVELS + l) < LOG2W); l++) begin
        {gw, pw} = ks_level(gw, pw, 1 << (s * STAGE_LEVELS + l));
      end
      grp_g_d[s] = gw;
      grp_p_d[s] = pw;
    end
  end

  // Group generates are the carries out of each bit position.
  always_comb begin
    sum_d  = po_q[NSTG-1] ^ {grp_g_d[NSTG-1][WIDTH-2:0], cin_q[NSTG-1]};
    cout_d = grp_g_d[NSTG-1][WIDTH-1];
  end

  // Pipeline registers: everything holds while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      cin_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      for (int s = 0; s < NSTG; s++) begin
        g_q[s]  <= '0;
        p_q[s]  <= '0;
        po_q[s] <= '0;
      end
    end else if (!stall_d) begin
      vld_q[0] <= bus.in_valid;
      if (bus.in_valid) begin
        g_q[0]   <= g0_d;
        p_q[0]   <= p0_d;
        po_q[0]  <= p0_d;
        cin_q[0] <= cin0_d;
      end
      for (int s = 1; s < NSTG; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) begin
          g_q[s]   <= grp_g_d[s-1];
          p_q[s]   <= grp_p_d[s-1];
          po_q[s]  <= po_q[s-1];
          cin_q[s] <= cin_q[s-1];
        end
      end
      // Output data only changes on a real beat so it keeps the last result.
      out_valid_q <= vld_q[NSTG-1];
      if (vld_q[NSTG-1]) begin
        out_sum_q  <= sum_d;
        out_cout_q <= cout_d;
      end
    end
  end
endmodule

// File: tb/tb_ks_pipe_adder.sv
// Directed and stress bench for ks_pipe_adder: 16-bit/2-level and 13-bit/1-level instances.
`timescale 1ns/1ps
module tb_ks_pipe_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int out1_cnt = 0;
  int out2_cnt = 0;
  logic [16:0] exp1_q[$];
  logic [13:0] exp2_q[$];

  ks_pipe_if #(.WIDTH(16)) bus1 ();
  ks_pipe_if #(.WIDTH(13)) bus2 ();

  ks_pipe_adder #(.WIDTH(16), .STAGE_LEVELS(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  ks_pipe_adder #(.WIDTH(13), .STAGE_LEVELS(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard checks for every output transfer.
  always @(negedge clk) begin
    if (rst_n && bus1.out_valid && bus1.out_ready) begin
      out1_cnt++;
      if (exp1_q.size() == 0) check_eq("dut1_extra_beat", exp1_q.size(), 1);
      else check_eq("dut1_result", {15'd0, bus1.out_cout, bus1.out_sum}, {15'd0, exp1_q.pop_front()});
    end
    if (rst_n && bus2.out_valid && bus2.out_ready) begin
      out2_cnt++;
      if (exp2_q.size() == 0) check_eq("dut2_extra_beat", exp2_q.size(), 1);
      else check_eq("dut2_result", {18'd0, bus2.out_cout, bus2.out_sum}, {18'd0, exp2_q.pop_front()});
    end
  end

  task automatic drive1(input logic [15:0] a, input logic [15:0] b, input logic cin);
    bit acc = 1'b0;
    bus1.in_valid = 1'b1;
    bus1.in_a = a;
    bus1.in_b = b;
    bus1.in_cin = cin;
    for (int t = 0; t < 64 && !acc; t++) begin
      @(negedge clk);
      if (bus1.in_ready) begin
        acc = 1'b1;
        exp1_q.push_back(17'(a) + 17'(b) + 17'(cin));
      end
      @(posedge clk); #1;
    end
    bus1.in_valid = 1'b0;
    if (!acc) check_eq("dut1_accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic wait_out1(input string tag, input int lat, input logic [16:0] exp);
    int n = 1;
    bit found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (bus1.out_valid) found = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    check_eq({tag, "_lat"}, n, lat);
    check_eq({tag, "_val"}, {15'd0, bus1.out_cout, bus1.out_sum}, {15'd0, exp});
    @(posedge clk); #1;
  endtask

  task automatic drain1(input string tag);
    for (int t = 0; t < 50 && exp1_q.size() != 0; t++) @(posedge clk);
    #1;
    check_eq(tag, exp1_q.size(), 0);
  endtask

  task automatic single2(input string tag, input logic [12:0] a, input logic [12:0] b,
                         input logic cin, input logic sub, input logic [13:0] exp);
    int n = 1;
    bit found = 1'b0;
    logic [12:0] nb;
    nb = ~b;
    bus2.in_valid = 1'b1;
    bus2.in_a = a;
    bus2.in_b = b;
    bus2.in_cin = cin;
`ifdef KS_PIPE_SUB_EN
    bus2.in_sub = sub;
`endif
    @(negedge clk);
    check_eq({tag, "_ready"}, bus2.in_ready, 1);
    exp2_q.push_back(sub ? 14'(a) + 14'(nb) + 14'd1 : 14'(a) + 14'(b) + 14'(cin));
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (bus2.out_valid) found = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    check_eq({tag, "_lat"}, n, 5);
    check_eq({tag, "_val"}, {18'd0, bus2.out_cout, bus2.out_sum}, {18'd0, exp});
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] held;
    int c0;
    int start;
    int sent;
    bit pend;
    logic [12:0] ra, rb, nrb;
    logic rc, rs;

    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_cin = 1'b0; bus1.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.in_cin = 1'b0; bus2.out_ready = 1'b1;
`ifdef KS_PIPE_SUB_EN
    bus1.in_sub = 1'b0;
    bus2.in_sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", bus1.out_valid, 0);
    check_eq("rst_out_sum", {16'd0, bus1.out_sum}, 0);
    check_eq("rst_out_cout", bus1.out_cout, 0);
    check_eq("rst_in_ready", bus1.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed sums and wrap-around
    drive1(16'h1234, 16'h4321, 1'b0);
    wait_out1("t1_basic", 3, 17'h05555);
    drive1(16'hFFFF, 16'h0000, 1'b1);
    wait_out1("t2_wrap", 3, 17'h10000);
    drive1(16'h8000, 16'h8000, 1'b0);
    wait_out1("t2_msb", 3, 17'h10000);
    drive1(16'hFFFF, 16'hFFFF, 1'b1);
    wait_out1("t2_ones", 3, 17'h1FFFF);

    // Full-rate streaming
    c0 = out1_cnt;
    start = cyc;
    for (int i = 0; i < 100; i++) drive1(16'(i * 32'h1357 + 32'h00A5), 16'(i * 32'h2C91 + 32'h7001), 1'(i >> 1));
    check_eq("t3_throughput", cyc - start, 100);
    drain1("t3_drain");
    check_eq("t3_count", out1_cnt - c0, 100);

    // Backpressure for 5 cycles
    c0 = out1_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++) drive1(16'(i * 32'h1111), 16'(32'hF000 - i), 1'(i));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus1.out_ready = 1'b0;
        held = exp1_q[0];
        repeat (5) begin
          @(negedge clk);
          check_eq("t4_in_ready", bus1.in_ready, 0);
          check_eq("t4_out_valid", bus1.out_valid, 1);
          check_eq("t4_hold", {15'd0, bus1.out_cout, bus1.out_sum}, {15'd0, held});
          @(posedge clk); #1;
        end
        bus1.out_ready = 1'b1;
      end
    join
    drain1("t4_drain");
    check_eq("t4_count", out1_cnt - c0, 8);

    // Reset with beats in flight
    drive1(16'h0101, 16'h0202, 1'b0);
    drive1(16'h0303, 16'h0404, 1'b1);
    drive1(16'h0505, 16'h0606, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", bus1.out_valid, 0);
    check_eq("t5_rst_sum", {16'd0, bus1.out_sum}, 0);
    check_eq("t5_rst_cout", bus1.out_cout, 0);
    exp1_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive1(16'hA5A5, 16'h5A5A, 1'b1);
    wait_out1("t5_after_rst", 3, 17'h10000);

    // 13-bit, one level per stage
    single2("t6_wrap", 13'h1FFF, 13'h0001, 1'b0, 1'b0, 14'h2000);
    single2("t6_basic", 13'h0ABC, 13'h0123, 1'b1, 1'b0, 14'h0BE0);
`ifdef KS_PIPE_SUB_EN
    single2("t6_sub", 13'h0005, 13'h0007, 1'b0, 1'b1, 14'h1FFE);
    single2("t6_sub_ge", 13'h0007, 13'h0005, 1'b0, 1'b1, 14'h2002);
`endif
    c0 = out2_cnt;
    sent = 0;
    pend = 1'b0;
    for (int c = 0; c < 600 && sent < 60; c++) begin
      bus2.out_ready = ($urandom_range(0, 3) != 0);
      if (!pend && $urandom_range(0, 4) != 0) begin
        ra = 13'($urandom);
        rb = 13'($urandom);
        rc = 1'($urandom);
        rs = 1'($urandom);
        bus2.in_valid = 1'b1;
        bus2.in_a = ra;
        bus2.in_b = rb;
        bus2.in_cin = rc;
`ifdef KS_PIPE_SUB_EN
        bus2.in_sub = rs;
`else
        rs = 1'b0;
`endif
        pend = 1'b1;
      end else if (!pend) begin
        bus2.in_valid = 1'b0;
      end
      @(negedge clk);
      if (pend && bus2.in_ready) begin
        nrb = ~rb;
        exp2_q.push_back(rs ? 14'(ra) + 14'(nrb) + 14'd1 : 14'(ra) + 14'(rb) + 14'(rc));
        pend = 1'b0;
        sent++;
      end
      @(posedge clk); #1;
    end
    bus2.in_valid = 1'b0;
    bus2.out_ready = 1'b1;
    check_eq("t6_sent", sent, 60);
    for (int t = 0; t < 50 && exp2_q.size() != 0; t++) @(posedge clk);
    #1;
    check_eq("t6_drain", exp2_q.size(), 0);
    check_eq("t6_count", out2_cnt - c0, 60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
